// File: rtl/control_unit_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_mc_if
//  Description : Bundle between the multicycle control unit and its datapath.
//                master = control unit side, slave = datapath side.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_mc_if #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
);
    // Datapath status toward the control unit
    logic             zero;
    logic [OP_W-1:0]  op_code;
    logic             mem_ready;

    // Control outputs toward the datapath
    logic             EscCP;
    logic [OP_W-1:0]  ULA_OP;
    logic             ULA_A;
    logic [1:0]       ULA_B;
    logic             EscIR;
    logic [1:0]       FonteCP;
    logic             EscReg;
    logic             MemToReg;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  zero, op_code, mem_ready,
        output EscCP, ULA_OP, ULA_A, ULA_B, EscIR, FonteCP, EscReg, MemToReg,
               mem_req, mem_we, halted, instr_retired
    );

    modport slave (
        output zero, op_code, mem_ready,
        input  EscCP, ULA_OP, ULA_A, ULA_B, EscIR, FonteCP, EscReg, MemToReg,
               mem_req, mem_we, halted, instr_retired
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_mc
//  Description : Multicycle control unit FSM (FETCH/EXEC/MEM/WB/PCUPD/HALT)
//                with a wrapping retired-instruction counter.
//                Optional macro WAIT_STATE_EN: FETCH and MEM stall until
//                mem_ready; otherwise mem_ready is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit_mc #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    control_unit_mc_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_PCUPD = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] instr_retired_q, instr_retired_d;

    // Opcode decode: any opcode with bits above [3:0] set is a NOP
    logic       w_op_hi;
    logic [3:0] w_op_lo;

    assign w_op_lo = bus.op_code[3:0];

    generate
        if (OP_W > 4) begin : g_op_wide
            assign w_op_hi = |bus.op_code[OP_W-1:4];
        end else begin : g_op_narrow
            assign w_op_hi = 1'b0;
        end
    endgenerate

    logic w_is_alu_reg, w_is_alu_imm, w_is_jmp, w_is_bez;
    logic w_is_ld, w_is_st, w_is_hlt;

    // Classify the opcode held in the instruction register
    always_comb begin
        w_is_alu_reg = 1'b0;
        w_is_alu_imm = 1'b0;
        w_is_jmp     = 1'b0;
        w_is_bez     = 1'b0;
        w_is_ld      = 1'b0;
        w_is_st      = 1'b0;
        w_is_hlt     = 1'b0;
        if (!w_op_hi) begin
            case (w_op_lo)
                4'd0, 4'd1, 4'd3, 4'd4, 4'd5:          w_is_alu_reg = 1'b1;
                4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:   w_is_alu_imm = 1'b1;
                4'd11:                                 w_is_jmp     = 1'b1;
                4'd12:                                 w_is_bez     = 1'b1;
                4'd13:                                 w_is_ld      = 1'b1;
                4'd14:                                 w_is_st      = 1'b1;
                default:                               w_is_hlt     = 1'b1;
            endcase
        end
    end

    // Memory handshake: with wait states, FETCH/MEM advance only on mem_ready
    logic w_mem_done;
`ifdef WAIT_STATE_EN
    assign w_mem_done = bus.mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = bus.mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    logic            w_esc_cp, w_ula_a, w_esc_ir, w_esc_reg, w_mem_to_reg;
    logic            w_mem_req, w_mem_we, w_halted;
    logic [OP_W-1:0] w_ula_op;
    logic [1:0]      w_ula_b, w_fonte_cp;

    // Next-state, zero flag capture, retire counter and per-state outputs
    always_comb begin
        state_d         = state_q;
        zero_d          = zero_q;
        instr_retired_d = instr_retired_q;
        w_esc_cp        = 1'b0;
        w_ula_op        = '0;
        w_ula_a         = 1'b0;
        w_ula_b         = 2'd0;
        w_esc_ir        = 1'b0;
        w_fonte_cp      = 2'd0;
        w_esc_reg       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_mem_req       = 1'b0;
        w_mem_we        = 1'b0;
        w_halted        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                w_esc_ir  = w_mem_done;
                if (w_mem_done) begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_ula_op = bus.op_code;
                state_d  = ST_PCUPD;
                if (w_is_alu_reg) begin
                    w_ula_a   = 1'b1;
                    w_esc_reg = 1'b1;
                end else if (w_is_alu_imm) begin
                    w_ula_a   = 1'b1;
                    w_ula_b   = 2'd2;
                    w_esc_reg = 1'b1;
                end else if (w_is_bez) begin
                    w_ula_a = 1'b1;
                    zero_d  = bus.zero;
                end else if (w_is_ld || w_is_st) begin
                    // Address = reg_a + immediate, ALU forced to add
                    w_ula_op = '0;
                    w_ula_a  = 1'b1;
                    w_ula_b  = 2'd2;
                    state_d  = ST_MEM;
                end else if (w_is_hlt) begin
                    state_d = ST_HALT;
                end
            end

            ST_MEM: begin
                w_mem_req = 1'b1;
                w_mem_we  = w_is_st;
                if (w_mem_done) begin
                    state_d = w_is_ld ? ST_WB : ST_PCUPD;
                end
            end

            ST_WB: begin
                w_esc_reg    = 1'b1;
                w_mem_to_reg = 1'b1;
                state_d      = ST_PCUPD;
            end

            ST_PCUPD: begin
                w_esc_cp = 1'b1;
                w_ula_b  = 2'd1;
                if (w_is_jmp) begin
                    w_fonte_cp = 2'd2;
                end else if (w_is_bez && zero_q) begin
                    w_fonte_cp = 2'd1;
                end
                instr_retired_d = instr_retired_q + CNT_W'(1);
                state_d         = ST_FETCH;
            end

            ST_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State, branch flag and retire counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_FETCH;
            zero_q          <= 1'b0;
            instr_retired_q <= '0;
        end else begin
            state_q         <= state_d;
            zero_q          <= zero_d;
            instr_retired_q <= instr_retired_d;
        end
    end

    // Outputs are forced low while reset is asserted, without waiting for a clock
    assign bus.EscCP         = rst_n & w_esc_cp;
    assign bus.ULA_OP        = rst_n ? w_ula_op : '0;
    assign bus.ULA_A         = rst_n & w_ula_a;
    assign bus.ULA_B         = rst_n ? w_ula_b : 2'd0;
    assign bus.EscIR         = rst_n & w_esc_ir;
    assign bus.FonteCP       = rst_n ? w_fonte_cp : 2'd0;
    assign bus.EscReg        = rst_n & w_esc_reg;
    assign bus.MemToReg      = rst_n & w_mem_to_reg;
    assign bus.mem_req       = rst_n & w_mem_req;
    assign bus.mem_we        = rst_n & w_mem_we;
    assign bus.halted        = rst_n & w_halted;
    assign bus.instr_retired = instr_retired_q;

endmodule
`default_nettype wire
